rx_link_ctrl: RTL and testbench
===============================

// Module: rx_link_ctrl
// PURPOSE
//  Link-synchronisation controller for the RX byte datapath. Sits between the
//  serial-to-parallel converter and the lane demux tree.
//  Tracks comma symbols (0xBC) to declare the link active, and gates data valid
//  toward the demuxes. Drops back to search when framing is lost (comma starvation).
// PARAMETERS
//  COMMA       8'hBC  comma/idle symbol
//  LOCK_COUNT  4      consecutive commas required to enter ACTIVE (>=1)
//  MAX_RUN     16     max consecutive non-comma bytes tolerated in ACTIVE (>=1)
// PORTS
//  clk_4f      in   1  byte clock; all logic on rising edge
//  reset       in   1  asynchronous, active-low reset
//  byte_in     in   8  parallel byte from serial-to-parallel stage
//  byte_vld    in   1  byte_in holds a new byte this cycle
//  data_out    out  8  payload byte to demux tree
//  valid_out   out  1  data_out holds payload this cycle (one cycle per byte)
//  active      out  1  link synchronised (state==ACTIVE)
//  lost        out  1  one-cycle pulse on loss of sync
//  state       out  2  0=SEARCH 1=LOCKING 2=ACTIVE 3=LOST
//  err_count   out  8  loss-of-sync event count (see CONFIGURATION)
// BEHAVIOUR
//  - reset low (async): state=SEARCH, comma_cnt=0, run_cnt=0, data_out=0,
//    valid_out=0, active=0, lost=0, err_count=0; held until reset released.
//  - All outputs registered; a byte accepted at edge N drives outputs after edge N.
//    Latency 1 clk_4f cycle.
//  - byte_vld=0: state and counters hold; valid_out=0, lost=0; data_out holds.
//  - SEARCH: comma -> LOCKING, comma_cnt=1 (LOCK_COUNT==1 -> ACTIVE directly);
//    non-comma -> stay.
//  - LOCKING: comma -> comma_cnt+1; comma_cnt reaching LOCK_COUNT -> ACTIVE,
//    run_cnt=0. Non-comma -> SEARCH, comma_cnt=0 (no LOST pulse: never locked).
//  - ACTIVE: active=1.
//    - comma = idle: valid_out=0, run_cnt=0.
//    - non-comma: data_out=byte_in, valid_out=1, run_cnt+1.
//    - A byte that would make run_cnt exceed MAX_RUN -> LOST; that byte is dropped
//      (valid_out=0). Exactly MAX_RUN data bytes in a row are still accepted.
//  - LOST: one cycle, independent of byte_vld. lost=1, active=0, counters cleared,
//    then SEARCH. The byte presented in this cycle is ignored.
//  - active is asserted in the same cycle state becomes ACTIVE and deasserts the
//    cycle state leaves ACTIVE. Commas never produce valid_out.
//  - Counter widths: $clog2(LOCK_COUNT+1) and $clog2(MAX_RUN+1); no wrap possible.
//  - Reset mid-operation: asynchronous clear wins regardless of state; an in-flight
//    valid_out is cancelled immediately.
// CONFIGURATION
//  RX_LINK_ERR_CNT_EN defined:
//    - err_count increments by 1 on each entry into LOST.
//    - Saturates at 8'hFF; cleared only by reset.
//  RX_LINK_ERR_CNT_EN undefined:
//    - err_count is constant 8'h00; no counter logic; lost and state unaffected.
// TESTING
//  1. Reset low mid-ACTIVE with byte_vld=1 -> all outputs 0 and state=0 on the
//     same cycle, independent of clk_4f.
//  2. Defaults; 4x 0xBC then 0x11,0x22 -> active=1 the cycle after the 4th comma;
//     valid_out=1 with data_out 0x11 then 0x22.
//  3. BC,BC,BC,0x55,BC -> back to SEARCH at 0x55 (active never 1, lost never 1);
//     final BC gives state=LOCKING.
//  4. ACTIVE, then 16 data bytes then BC -> 16 valid_out pulses, no lost.
//     Repeat with 17 data bytes -> 17th dropped, lost=1 for 1 cycle, state=SEARCH.
//  5. ACTIVE with byte_vld toggling 1/0 -> valid_out only on vld cycles; run_cnt and
//     state hold across gaps.
//  6. With RX_LINK_ERR_CNT_EN: 3 forced loss events -> err_count=3; 256 events ->
//     saturates at 8'hFF. Without the macro -> err_count stays 8'h00.

Source files
------------

// File: rtl/rx_link_ctrl.sv
// RX link-synchronisation controller: comma-based lock, payload gating, loss-of-sync detect.
// Optional loss-event counter enabled by defining RX_LINK_ERR_CNT_EN.
module rx_link_ctrl #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_RUN    = 16
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       lost,
    output logic [1:0] state,
    output logic [7:0] err_count
);

    localparam int CW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] LOCK_C = CW'(LOCK_COUNT);
    localparam logic [RW-1:0] MAX_R  = RW'(MAX_RUN);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_LOCKING = 2'd1,
        S_ACTIVE  = 2'd2,
        S_LOST    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   comma_cnt_q, comma_cnt_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            valid_q, valid_d;
    logic            lost_q, lost_d;
    logic            active_q, active_d;
    logic            is_comma;
    logic            accept;

    assign is_comma = (byte_in == COMMA);
    // A payload byte is taken only while the run budget still has room.
    assign accept = (state_q == S_ACTIVE) && byte_vld && !is_comma && (run_cnt_q != MAX_R);

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q     <= S_SEARCH;
            comma_cnt_q <= '0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        run_cnt_d   = run_cnt_q;
        case (state_q)
            S_SEARCH: begin
                if (byte_vld && is_comma) begin
                    if (LOCK_COUNT == 1) begin
                        state_d     = S_ACTIVE;
                        comma_cnt_d = '0;
                        run_cnt_d   = '0;
                    end else begin
                        state_d     = S_LOCKING;
                        comma_cnt_d = CW'(1);
                    end
                end
            end
            S_LOCKING: begin
                if (byte_vld) begin
                    if (!is_comma) begin
                        state_d     = S_SEARCH;
                        comma_cnt_d = '0;
                    end else if (comma_cnt_q + CW'(1) == LOCK_C) begin
                        state_d     = S_ACTIVE;
                        comma_cnt_d = '0;
                        run_cnt_d   = '0;
                    end else begin
                        comma_cnt_d = comma_cnt_q + CW'(1);
                    end
                end
            end
            S_ACTIVE: begin
                if (byte_vld) begin
                    if (is_comma) begin
                        run_cnt_d = '0;
                    end else if (run_cnt_q == MAX_R) begin
                        state_d     = S_LOST;
                        comma_cnt_d = '0;
                        run_cnt_d   = '0;
                    end else begin
                        run_cnt_d = run_cnt_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d     = S_SEARCH;
                comma_cnt_d = '0;
                run_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        lost_d     = (state_d == S_LOST);
        active_d   = (state_d == S_ACTIVE);
        if (accept) begin
            data_out_d = byte_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            lost_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            lost_q     <= lost_d;
            active_q   <= active_d;
        end
    end

`ifdef RX_LINK_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (state_d == S_LOST && state_q != S_LOST && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) err_count_q <= 8'h00;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign lost      = lost_q;
    assign active    = active_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Directed bench for rx_link_ctrl: lock, payload gating, run limit, gaps, async reset, loss counter.
module tb_rx_link_ctrl;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_vld;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       lost;
    logic [1:0] state;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;
    int err_exp  = 0;

    rx_link_ctrl dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .byte_in   (byte_in),
        .byte_vld  (byte_vld),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .lost      (lost),
        .state     (state),
        .err_count (err_count)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present one byte for one clock; outputs are then examined 1 time unit after the edge.
    task automatic send(input logic [7:0] b, input logic v);
        @(negedge clk_4f);
        byte_in  = b;
        byte_vld = v;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic go_active();
        for (int i = 0; i < 4; i++) send(8'hBC, 1'b1);
        chk("go_active_state", state, 2);
    endtask

    task automatic force_loss();
        go_active();
        for (int i = 0; i < 17; i++) send(8'h40, 1'b1);
        chk("force_loss_lost", lost, 1);
        send(8'h00, 1'b0);
        if (err_exp < 255) err_exp++;
    endtask

    function automatic int err_model();
`ifdef RX_LINK_ERR_CNT_EN
        return err_exp;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk_4f);
        reset = 1'b0;
        byte_vld = 1'b0;
        byte_in = 8'h00;
        @(negedge clk_4f);
        reset = 1'b1;
        err_exp = 0;
    endtask

    initial begin
        reset    = 1'b0;
        byte_in  = 8'h00;
        byte_vld = 1'b0;
        #23;
        chk("rst_state", state, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_active", active, 0);
        chk("rst_lost", lost, 0);
        chk("rst_err", err_count, 0);
        @(negedge clk_4f);
        reset = 1'b1;

        // Lock on four commas, then payload.
        send(8'hBC, 1'b1); chk("lk1_state", state, 1); chk("lk1_active", active, 0);
        send(8'hBC, 1'b1); chk("lk2_state", state, 1);
        send(8'hBC, 1'b1); chk("lk3_state", state, 1); chk("lk3_active", active, 0);
        send(8'hBC, 1'b1); chk("lk4_state", state, 2); chk("lk4_active", active, 1);
        chk("lk4_valid", valid_out, 0);
        send(8'h11, 1'b1); chk("d11_valid", valid_out, 1); chk("d11_data", data_out, 8'h11);
        send(8'h22, 1'b1); chk("d22_valid", valid_out, 1); chk("d22_data", data_out, 8'h22);
        send(8'hBC, 1'b1); chk("idle_valid", valid_out, 0); chk("idle_data_hold", data_out, 8'h22);

        // Exactly 16 data bytes accepted, then a comma.
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h60 + i), 1'b1);
            chk("run16_valid", valid_out, 1);
            chk("run16_data", data_out, 8'(8'h60 + i));
            chk("run16_lost", lost, 0);
        end
        send(8'hBC, 1'b1); chk("run16_end_state", state, 2); chk("run16_end_valid", valid_out, 0);

        // 17 data bytes: 17th dropped with a loss pulse.
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b1);
        chk("run17_16th_valid", valid_out, 1);
        send(8'hEE, 1'b1);
        chk("run17_valid", valid_out, 0);
        chk("run17_lost", lost, 1);
        chk("run17_state", state, 3);
        chk("run17_active", active, 0);
        chk("run17_data_hold", data_out, 8'h8F);
        err_exp++;
        chk("run17_err", err_count, err_model());
        send(8'hBC, 1'b1);
        chk("after_lost_state", state, 0);
        chk("after_lost_pulse", lost, 0);

        // Gapped traffic: run count holds across idle byte_vld cycles.
        go_active();
        for (int i = 0; i < 16; i++) begin
            send(8'(8'hA0 + i), 1'b1);
            chk("gap_vld_valid", valid_out, 1);
            send(8'hBC, 1'b0);
            chk("gap_idle_valid", valid_out, 0);
            chk("gap_idle_state", state, 2);
            chk("gap_idle_data", data_out, 8'(8'hA0 + i));
        end
        send(8'h33, 1'b1);
        chk("gap_over_lost", lost, 1);
        chk("gap_over_valid", valid_out, 0);
        err_exp++;
        send(8'hBC, 1'b0);
        chk("gap_lost_one_cycle", state, 0);
        chk("gap_err", err_count, err_model());

        // Async reset while ACTIVE with a valid byte in flight.
        go_active();
        send(8'h5A, 1'b1);
        chk("pre_rst_valid", valid_out, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_valid", valid_out, 0);
        chk("arst_active", active, 0);
        chk("arst_data", data_out, 0);
        chk("arst_err", err_count, 0);
        err_exp = 0;
        @(negedge clk_4f);
        byte_vld = 1'b0;
        reset = 1'b1;

        // Broken lock sequence returns to search without a loss pulse.
        send(8'hBC, 1'b1);
        send(8'hBC, 1'b1);
        send(8'hBC, 1'b1);
        send(8'h55, 1'b1);
        chk("brk_state", state, 0);
        chk("brk_active", active, 0);
        chk("brk_lost", lost, 0);
        send(8'hBC, 1'b1);
        chk("brk_relock_state", state, 1);
        send(8'h00, 1'b1);

        // Loss-event counter.
        do_reset();
        for (int i = 0; i < 3; i++) force_loss();
        chk("err3", err_count, err_model());
        for (int i = 0; i < 256; i++) force_loss();
        chk("err_sat", err_count, err_model());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
